// File: rtl/multiport_regfile_if.sv
// Register-file bus: read/write addresses and data, HI/LO product write, clear request and Ready.
// The master modport belongs to the requester; the slave modport belongs to the register file.
interface multiport_regfile_if #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic               ClearReq;
  logic [AW-1:0]      RS;
  logic [AW-1:0]      RT;
  logic [AW-1:0]      RD;
  logic [WIDTH-1:0]   WriteData;
  logic               RegWrite;
  logic               MulWrite;
  logic [2*WIDTH-1:0] MulData;
  logic [WIDTH-1:0]   ReadRS;
  logic [WIDTH-1:0]   ReadRT;
  logic [WIDTH-1:0]   ReadHI;
  logic [WIDTH-1:0]   ReadLO;
  logic               Ready;

  modport master (
    output ClearReq, RS, RT, RD, WriteData, RegWrite, MulWrite, MulData,
    input  ReadRS, ReadRT, ReadHI, ReadLO, Ready
  );

  modport slave (
    input  ClearReq, RS, RT, RD, WriteData, RegWrite, MulWrite, MulData,
    output ReadRS, ReadRT, ReadHI, ReadLO, Ready
  );
endinterface

// File: rtl/multiport_regfile.sv
// Two-read/one-write register file with HI/LO pair and sequential clear; reads combinational, writes land in 1 cycle.
// No backpressure: writes are dropped and reads return 0 while Ready is low (DEPTH-cycle clear after reset/ClearReq).
module multiport_regfile #(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 16,
  parameter int BYPASS = 1
) (
  input  logic          Clock,
  input  logic          ResetN,
  multiport_regfile_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    clr_idx_q;
  logic             ready_q;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             reg_we;
  logic [AW-1:0]    reg_wa;
  logic [WIDTH-1:0] reg_wd;
  logic             hl_we;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  logic [WIDTH-1:0] rs_dat;
  logic [WIDTH-1:0] rt_dat;
  logic [WIDTH-1:0] hi_dat;
  logic [WIDTH-1:0] lo_dat;

  // Reset only parks the sweep at index 0; clearing advances once ResetN is released.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q   <= ST_RUN;
            ready_q   <= 1'b1;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.ClearReq) begin
            state_q   <= ST_CLEAR;
            ready_q   <= 1'b0;
            clr_idx_q <= '0;
          end
        end
        default: begin
          state_q   <= ST_CLEAR;
          ready_q   <= 1'b0;
          clr_idx_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    reg_we = 1'b0;
    reg_wa = clr_idx_q;
    reg_wd = '0;
    hl_we  = 1'b0;
    hi_d   = '0;
    lo_d   = '0;
    if (ResetN) begin
      if (!ready_q) begin
        reg_we = 1'b1;
        hl_we  = (clr_idx_q == '0);
      end else if (!bus.ClearReq) begin
        // The edge that starts a clear swallows any write presented with it.
        reg_we = bus.RegWrite && (bus.RD != '0);
        reg_wa = bus.RD;
        reg_wd = bus.WriteData;
        hl_we  = bus.MulWrite;
        hi_d   = bus.MulData[2*WIDTH-1:WIDTH];
        lo_d   = bus.MulData[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (reg_we) begin
      regs_q[reg_wa] <= reg_wd;
    end
    if (hl_we) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    rs_dat = '0;
    rt_dat = '0;
    hi_dat = '0;
    lo_dat = '0;
    if (ready_q) begin
      if (bus.RS != '0) begin
        rs_dat = regs_q[bus.RS];
        if ((BYPASS != 0) && bus.RegWrite && (bus.RD == bus.RS)) begin
          rs_dat = bus.WriteData;
        end
      end
      if (bus.RT != '0) begin
        rt_dat = regs_q[bus.RT];
        if ((BYPASS != 0) && bus.RegWrite && (bus.RD == bus.RT)) begin
          rt_dat = bus.WriteData;
        end
      end
      hi_dat = hi_q;
      lo_dat = lo_q;
      if ((BYPASS != 0) && bus.MulWrite) begin
        hi_dat = bus.MulData[2*WIDTH-1:WIDTH];
        lo_dat = bus.MulData[WIDTH-1:0];
      end
    end
  end

  assign bus.ReadRS = rs_dat;
  assign bus.ReadRT = rt_dat;
  assign bus.ReadHI = hi_dat;
  assign bus.ReadLO = lo_dat;
  assign bus.Ready  = ready_q;

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: directed scenarios then random traffic, two DUTs (BYPASS=1 and BYPASS=0)
// sharing one stimulus stream and checked against a whole-file behavioural model.
module tb_multiport_regfile;

  localparam int W  = 24;
  localparam int D  = 16;
  localparam int AW = $clog2(D);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn;
  logic           clr;
  logic [AW-1:0]  rs, rt, rd;
  logic [W-1:0]   wd;
  logic           rw, mw;
  logic [2*W-1:0] md;

  multiport_regfile_if #(.WIDTH(W), .DEPTH(D)) bus_b ();
  multiport_regfile_if #(.WIDTH(W), .DEPTH(D)) bus_n ();

  assign bus_b.ClearReq = clr;  assign bus_n.ClearReq = clr;
  assign bus_b.RS = rs;         assign bus_n.RS = rs;
  assign bus_b.RT = rt;         assign bus_n.RT = rt;
  assign bus_b.RD = rd;         assign bus_n.RD = rd;
  assign bus_b.WriteData = wd;  assign bus_n.WriteData = wd;
  assign bus_b.RegWrite = rw;   assign bus_n.RegWrite = rw;
  assign bus_b.MulWrite = mw;   assign bus_n.MulWrite = mw;
  assign bus_b.MulData = md;    assign bus_n.MulData = md;

  multiport_regfile #(.WIDTH(W), .DEPTH(D), .BYPASS(1)) dut_b (
    .Clock (clk), .ResetN (rstn), .bus (bus_b.slave)
  );
  multiport_regfile #(.WIDTH(W), .DEPTH(D), .BYPASS(0)) dut_n (
    .Clock (clk), .ResetN (rstn), .bus (bus_n.slave)
  );

  // Model: contents as the architecture sees them, plus cycles left until Ready.
  logic [W-1:0] m_regs [D];
  logic [W-1:0] m_hi, m_lo;
  int           busy;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wipe();
    for (int i = 0; i < D; i++) m_regs[i] = '0;
    m_hi = '0;
    m_lo = '0;
    busy = D;
  endtask

  function automatic logic [W-1:0] exp_rd(input bit byp, input logic [AW-1:0] a);
    if (busy != 0 || a == '0) return '0;
    if (byp && rw && rd == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [W-1:0] exp_hl(input bit byp, input bit hi);
    logic [W-1:0] v;
    if (busy != 0) return '0;
    if (byp && mw) v = hi ? md[2*W-1:W] : md[W-1:0];
    else           v = hi ? m_hi : m_lo;
    return v;
  endfunction

  task automatic model_edge();
    if (!rstn) wipe();
    else if (busy > 0) busy--;
    else if (clr) wipe();
    else begin
      if (rw && rd != '0) m_regs[rd] = wd;
      if (mw) begin
        m_hi = md[2*W-1:W];
        m_lo = md[W-1:0];
      end
    end
  endtask

  task automatic settle();
    #1;
    chk("b_ready", bus_b.Ready,  (busy == 0));
    chk("b_rs",    bus_b.ReadRS, exp_rd(1'b1, rs));
    chk("b_rt",    bus_b.ReadRT, exp_rd(1'b1, rt));
    chk("b_hi",    bus_b.ReadHI, exp_hl(1'b1, 1'b1));
    chk("b_lo",    bus_b.ReadLO, exp_hl(1'b1, 1'b0));
    chk("n_ready", bus_n.Ready,  (busy == 0));
    chk("n_rs",    bus_n.ReadRS, exp_rd(1'b0, rs));
    chk("n_rt",    bus_n.ReadRT, exp_rd(1'b0, rt));
    chk("n_hi",    bus_n.ReadHI, exp_hl(1'b0, 1'b1));
    chk("n_lo",    bus_n.ReadLO, exp_hl(1'b0, 1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rw  = 1'b0;
    mw  = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; idle();
    rs = '0; rt = '0; rd = '0; wd = '0; md = '0;
    wipe();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    repeat (2) begin
      settle(); tick();
    end

    // Release: Ready low for 16 cycles, high on the 17th.
    rstn = 1'b1;
    repeat (D) begin
      settle(); tick();
    end
    settle();
    chk("ready_cyc17", bus_b.Ready, 1);

    rd = 4'd5; wd = 24'hABCDEF; rw = 1'b1; rs = 4'd1; rt = 4'd2;
    settle(); tick();
    idle(); rs = 4'd5; rt = 4'd0;
    settle();
    chk("r5_rs", bus_b.ReadRS, 24'hABCDEF);
    chk("r5_rt", bus_b.ReadRT, 0);
    tick();

    rd = 4'd3; wd = 24'h123456; rw = 1'b1; rs = 4'd3;
    settle();
    chk("fwd_b", bus_b.ReadRS, 24'h123456);
    chk("fwd_n", bus_n.ReadRS, 0);
    tick();
    idle();
    settle();
    chk("r3_n", bus_n.ReadRS, 24'h123456);
    tick();

    rd = 4'd0; wd = 24'hFFFFFF; rw = 1'b1; rs = 4'd0;
    settle();
    chk("r0_fwd", bus_b.ReadRS, 0);
    tick();
    idle();
    settle();
    chk("r0_after", bus_n.ReadRS, 0);
    tick();

    mw = 1'b1; md = 48'h000001_FFFFFE; rw = 1'b1; rd = 4'd7; wd = 24'h00000A; rs = 4'd7; rt = 4'd7;
    settle();
    chk("mul_hi_b", bus_b.ReadHI, 24'h000001);
    chk("mul_lo_b", bus_b.ReadLO, 24'hFFFFFE);
    chk("mul_hi_n", bus_n.ReadHI, 0);
    tick();
    idle();
    settle();
    chk("mul_hi", bus_n.ReadHI, 24'h000001);
    chk("mul_lo", bus_n.ReadLO, 24'hFFFFFE);
    chk("r7",     bus_n.ReadRT, 24'h00000A);
    tick();

    for (int i = 1; i < D; i++) begin
      rd = AW'(i); wd = W'($urandom()); rw = 1'b1; rs = AW'(i); rt = AW'(D - i);
      settle(); tick();
    end
    idle(); rs = 4'd9; rt = 4'd9;
    settle(); tick();

    // Clear with a write in the same edge, then reset mid-clear.
    clr = 1'b1; rw = 1'b1; rd = 4'd2; wd = 24'h555555;
    settle(); tick();
    idle(); rs = 4'd2;
    for (int c = 1; c < 8; c++) begin
      clr = (c == 3);
      rw  = (c == 5);
      rd  = 4'd4; wd = 24'h777777;
      settle(); tick();
    end
    idle();
    rstn = 1'b0;
    settle(); tick();
    rstn = 1'b1;
    repeat (D) begin
      settle(); tick();
    end
    for (int a = 0; a < D; a++) begin
      rs = AW'(a); rt = AW'(D - 1 - a);
      settle();
      chk("clr_rs", bus_b.ReadRS, 0);
      chk("clr_hi", bus_b.ReadHI, 0);
      tick();
    end

    for (int n = 0; n < 400; n++) begin
      rd  = AW'($urandom_range(0, D - 1));
      rs  = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, D - 1));
      rt  = ($urandom_range(0, 3) == 0) ? rs : AW'($urandom_range(0, D - 1));
      wd  = W'($urandom());
      md  = (2*W)'({$urandom(), $urandom()});
      rw  = $urandom_range(0, 1) == 1;
      mw  = $urandom_range(0, 2) == 0;
      clr = $urandom_range(0, 59) == 0;
      rstn = $urandom_range(0, 149) != 0;
      settle(); tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 24, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of general registers (power of two, >=2).
REQ-003 SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding.
REQ-004 SHALL derive AW = log2(DEPTH) for all address ports.
REQ-005 SHALL have a single clock and a synchronous, active-low reset, named as follows:
- Clock  in  1  sole clock, all state updates on rising edge.
- ResetN  in  1  synchronous active-low reset.
REQ-006 SHALL have the remaining ports:
- ClearReq  in  1  request full register clear while running.
- RS  in  AW  read port A address.
- RT  in  AW  read port B address.
- RD  in  AW  write address.
- WriteData  in  WIDTH  write data.
- RegWrite  in  1  write enable.
- MulWrite  in  1  HI/LO write enable.
- MulData  in  2*WIDTH  product; upper half to HI, lower half to LO.
- ReadRS  out  WIDTH  data at RS.
- ReadRT  out  WIDTH  data at RT.
- ReadHI  out  WIDTH  HI register.
- ReadLO  out  WIDTH  LO register.
- Ready  out  1  high when writes are accepted and reads are valid.

Function
REQ-007 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-008 In CLEAR, SHALL zero one register per cycle at index ClrIdx, incrementing ClrIdx from 0 to DEPTH-1.
REQ-009 In CLEAR, SHALL zero HI and LO in the first CLEAR cycle.
REQ-010 SHALL leave CLEAR for RUN on the cycle after ClrIdx = DEPTH-1 is cleared, so CLEAR lasts exactly DEPTH cycles.
REQ-011 In RUN, SHALL enter CLEAR with ClrIdx=0 on the clock edge where ClearReq=1.
- Any RegWrite or MulWrite in that same cycle is discarded.
REQ-012 ClearReq asserted during CLEAR SHALL be ignored; the clear does not restart.
REQ-013 Ready SHALL be 1 only in RUN.
REQ-014 Writes SHALL be accepted only when Ready=1; RegWrite and MulWrite are ignored otherwise.
REQ-015 While Ready=0, SHALL drive ReadRS, ReadRT, ReadHI and ReadLO to 0.
REQ-016 Register 0 SHALL always read 0; writes to RD=0 are discarded.
REQ-017 Read ports SHALL be combinational from current addresses and register contents; write latency is 1 cycle.
REQ-018 Forwarding when BYPASS=1 and Ready=1:
- RegWrite=1, RD!=0 and RS==RD: ReadRS SHALL equal WriteData in the same cycle; same rule for RT.
- MulWrite=1: ReadHI/ReadLO SHALL equal MulData halves in the same cycle.
REQ-019 When BYPASS=0, reads SHALL return the pre-edge stored value.
REQ-020 RegWrite and MulWrite in the same cycle SHALL both take effect; they target disjoint storage.
REQ-021 RS==RT SHALL return identical data on both ports.

Reset
REQ-022 ResetN=0 at a clock edge SHALL force CLEAR with ClrIdx=0 and Ready=0 next cycle, regardless of current state.
REQ-023 ResetN=0 held SHALL keep ClrIdx at 0.
- Clearing proceeds only once ResetN=1.
- Ready rises exactly DEPTH cycles after the first edge with ResetN=1.
REQ-024 Reset asserted mid-CLEAR SHALL restart the clear from index 0.
REQ-025 All outputs SHALL be 0 from the first edge with ResetN=0 onward.

Verification (defaults WIDTH=24, DEPTH=16)
REQ-026 Release ResetN, count edges -> Ready=0 for 16 cycles, Ready=1 on cycle 17; all reads 0.
REQ-027 Write RD=5, 0xABCDEF; next cycle RS=5, RT=0 -> ReadRS=0xABCDEF, ReadRT=0.
REQ-028 RegWrite RD=3, 0x123456 with RS=3, BYPASS=1 -> ReadRS=0x123456 same cycle; with BYPASS=0 -> old value 0.
REQ-029 Write RD=0, 0xFFFFFF -> RS=0 reads 0 afterwards.
REQ-030 MulWrite 0x000001_FFFFFE plus RegWrite RD=7, 0x00000A in the same cycle -> HI=0x000001, LO=0xFFFFFE, R7=0x00000A.
REQ-031 Fill R1..R15, pulse ClearReq with RegWrite RD=2 -> write dropped, Ready=0 for 16 cycles, all registers, HI and LO read 0.
- Reassert ResetN=0 at cycle 8 of that clear -> clear restarts from 0.
